// File: rtl/river_row_buffer_if.sv
// Avalon-style write port carrying terrain rows into river_row_buffer.
interface river_row_buffer_if;
    logic [15:0] writedata;
    logic        write;
    logic        chipselect;
    logic [2:0]  address;

    modport master (output writedata, write, chipselect, address);
    modport slave  (input  writedata, write, chipselect, address);
endinterface

// File: rtl/river_row_buffer.sv
// Circular terrain-row store feeding the VGA generator's river edges. Rows
// pushed during a frame scroll in at vblank; each line's row is fetched in hblank.
//
// Line fetch FSM
//   state | meaning
//   IDLE  | waiting for hcount 1280 of a line whose next scanline is visible
//   READ  | RAM read issued last cycle, read data now valid
//   LOAD  | boundary registers take the RAM row
module river_row_buffer #(
    parameter int DEPTH    = 512,
    parameter int VISIBLE  = 480,
    parameter int BW       = 10,
    parameter int PEND_MAX = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    river_row_buffer_if.slave bus,
    input  logic [10:0]       hcount,
    input  logic [9:0]        vcount,
    output logic [BW-1:0]     boundary_1,
    output logic [BW-1:0]     boundary_2,
    output logic [BW-1:0]     boundary_3,
    output logic [BW-1:0]     boundary_4,
    output logic [5:0]        pending,
    output logic              overflow
);
    localparam int         PW   = $clog2(DEPTH);
    localparam int         RW   = 4 * BW;
    localparam logic [9:0] VIS  = 10'(VISIBLE);
    localparam logic [5:0] PMAX = 6'(PEND_MAX);

    typedef enum logic [1:0] {IDLE, READ, LOAD} state_t;
    state_t state, state_nxt;

    logic [BW-1:0] stage_1, stage_2, stage_3, stage_4;
    logic [PW-1:0] top_ptr, top_new, wr_addr, rd_addr;
    logic [5:0]    pend_base;
    logic [9:0]    next_line;
    logic [RW-1:0] mem [DEPTH];
    logic [RW-1:0] rd_data;
    logic          wr_sel, do_commit, do_clear, frame_upd, accept;
    logic          rd_en, load_en;
    logic          unused_wdata;

    assign unused_wdata = &{1'b0, bus.writedata[15:BW]};

    assign wr_sel    = bus.chipselect && bus.write;
    assign do_commit = wr_sel && (bus.address == 3'd4);
    assign do_clear  = wr_sel && (bus.address == 3'd5);
    assign frame_upd = (vcount == VIS) && (hcount == 11'd0);

    // A commit coinciding with the frame update is addressed from the new top
    // and counts toward the next frame.
    always_comb begin
        top_new   = frame_upd ? top_ptr - PW'(pending) : top_ptr;
        pend_base = frame_upd ? 6'd0 : pending;
        accept    = do_commit && (pend_base < PMAX);
        wr_addr   = top_new - PW'(1) - PW'(pend_base);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_1  <= '0;
            stage_2  <= '0;
            stage_3  <= '0;
            stage_4  <= '0;
            top_ptr  <= '0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_sel) begin
                case (bus.address)
                    3'd0:    stage_1 <= bus.writedata[BW-1:0];
                    3'd1:    stage_2 <= bus.writedata[BW-1:0];
                    3'd2:    stage_3 <= bus.writedata[BW-1:0];
                    3'd3:    stage_4 <= bus.writedata[BW-1:0];
                    default: ;
                endcase
            end
            top_ptr <= top_new;
            pending <= accept ? pend_base + 6'd1 : pend_base;
            if (do_commit && !accept)
                overflow <= 1'b1;
            else if (do_clear)
                overflow <= 1'b0;
        end
    end

    // Row RAM: contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_addr] <= {stage_1, stage_2, stage_3, stage_4};
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        load_en   = 1'b0;
        next_line = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
        rd_addr   = top_ptr + PW'(next_line);
        case (state)
            IDLE: begin
                if ((hcount == 11'd1280) && (next_line < VIS)) begin
                    rd_en     = 1'b1;
                    state_nxt = READ;
                end
            end
            READ: state_nxt = LOAD;
            LOAD: begin
                load_en   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            boundary_1 <= '0;
            boundary_2 <= '0;
            boundary_3 <= '0;
            boundary_4 <= '0;
        end else if (load_en) begin
            {boundary_1, boundary_2, boundary_3, boundary_4} <= rd_data;
        end
    end
endmodule

// File: tb/tb_river_row_buffer.sv
// Scoreboard bench for river_row_buffer with compressed VGA timing and a
// row-per-scanline reference model.
module tb_river_row_buffer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [9:0]  b1, b2, b3, b4;
    logic [5:0]  pending;
    logic        overflow;

    always #10 clk = ~clk;

    river_row_buffer_if bus();

    river_row_buffer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus),
        .hcount     (hcount),
        .vcount     (vcount),
        .boundary_1 (b1),
        .boundary_2 (b2),
        .boundary_3 (b3),
        .boundary_4 (b4),
        .pending    (pending),
        .overflow   (overflow)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [39:0] row;
        bit          known;
    } exp_t;

    // Reference model: a 512-row picture store addressed by scanline offset.
    logic [39:0] m_mem [512];
    bit          m_valid [512];
    int          m_top, m_pend, n_top, n_pend;
    bit          m_ovf, n_ovf;
    logic [9:0]  m_stage [4];
    logic [9:0]  n_stage [4];
    exp_t        exp_q [$];
    logic [39:0] held;
    bit          held_known;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_bnd(input string name, input int e1, input int e2, input int e3, input int e4);
        chk(name, {b1, b2, b3, b4}, {10'(e1), 10'(e2), 10'(e3), 10'(e4)});
    endtask

    task automatic model_reset();
        m_top  = 0;
        m_pend = 0;
        m_ovf  = 1'b0;
        for (int i = 0; i < 4; i++) m_stage[i] = '0;
        exp_q.delete();
        held       = '0;
        held_known = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict the state after the coming edge.
    task automatic step(input int h, input int v, input bit we = 1'b0,
                        input int a = 0, input int d = 0);
        int   nl, idx;
        exp_t e;
        hcount         = 11'(h);
        vcount         = 10'(v);
        bus.write      = we;
        bus.chipselect = we;
        bus.address    = 3'(a);
        bus.writedata  = 16'(d);
        n_top   = m_top;
        n_pend  = m_pend;
        n_ovf   = m_ovf;
        n_stage = m_stage;
        if (h == 1280) begin
            nl = (v == 524) ? 0 : v + 1;
            if (nl < 480) begin
                idx     = (m_top + nl) % 512;
                e.row   = m_mem[idx];
                e.known = m_valid[idx];
                exp_q.push_back(e);
            end
        end
        if (v == 480 && h == 0) begin
            n_top  = (m_top - m_pend + 512) % 512;
            n_pend = 0;
        end
        if (we) begin
            if (a < 4) begin
                n_stage[a] = 10'(d);
            end else if (a == 4) begin
                if (n_pend < 31) begin
                    idx          = (n_top - 1 - n_pend + 1024) % 512;
                    m_mem[idx]   = {m_stage[0], m_stage[1], m_stage[2], m_stage[3]};
                    m_valid[idx] = 1'b1;
                    n_pend++;
                end else begin
                    n_ovf = 1'b1;
                end
            end else if (a == 5) begin
                n_ovf = 1'b0;
            end
        end
        @(posedge clk);
        m_top   = n_top;
        m_pend  = n_pend;
        m_ovf   = n_ovf;
        m_stage = n_stage;
        #1;
    endtask

    task automatic line(input int v, input bit commit0 = 1'b0);
        int hs [8] = '{0, 1, 1279, 1280, 1281, 1282, 1283, 1599};
        for (int i = 0; i < 8; i++)
            step(hs[i], v, commit0 && (i == 0), 4, 0);
    endtask

    task automatic wr(input int v, input int a, input int d);
        step(640, v, 1'b1, a, d);
    endtask

    task automatic rand_frame();
        line(524);
        line(0);
        line(1);
        line($urandom_range(2, 478));
        for (int i = 0; i < 4; i++) wr(479, i, $urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0) wr(479, 6 + $urandom_range(0, 1), $urandom);
        wr(479, 4, 0);
        line(479);
        line(480);
        line(500);
    endtask

    // Monitor: pops a fetched row when the line's output becomes visible and
    // checks that the boundaries hold that row on every other cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("mon_pending", pending, m_pend);
                chk("mon_overflow", overflow, m_ovf);
                if (hcount == 11'd1283 && exp_q.size() > 0) begin
                    e          = exp_q.pop_front();
                    held       = e.row;
                    held_known = e.known;
                end
                if (held_known)
                    chk("mon_boundary", {b1, b2, b3, b4}, held);
            end
        end
    end

    initial begin
        reset_n        = 1'b0;
        hcount         = '0;
        vcount         = '0;
        bus.write      = 1'b0;
        bus.chipselect = 1'b0;
        bus.address    = '0;
        bus.writedata  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pending", pending, 0);
        chk("reset_overflow", overflow, 0);
        chk_bnd("reset_boundary", 0, 0, 0, 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Rows A then B; B lands on scanline 0, A on scanline 1.
        line(0);
        wr(10, 0, 10); wr(10, 1, 20); wr(10, 2, 0); wr(10, 3, 0); wr(10, 4, 0);
        wr(10, 0, 30); wr(10, 1, 40); wr(10, 2, 50); wr(10, 3, 60); wr(10, 4, 0);
        chk("two_commits_pending", pending, 2);
        line(479);
        line(480);
        chk("update_pending", pending, 0);
        line(500);
        line(524);
        chk_bnd("scan0_B", 30, 40, 50, 60);
        line(0);
        chk_bnd("scan1_A", 10, 20, 0, 0);
        line(1);

        // Thirty-two commits: the last one is dropped.
        for (int i = 0; i < 32; i++) begin
            wr(20, 0, 100 + i);
            wr(20, 4, 0);
        end
        chk("ovf_pending", pending, 31);
        chk("ovf_set", overflow, 1);
        line(480);
        line(524);
        chk_bnd("ovf_scan0", 130, 40, 50, 60);
        line(0);
        wr(1, 5, 16'hffff);
        chk("ovf_clear", overflow, 0);

        // Commit coinciding with the frame update.
        wr(5, 0, 200); wr(5, 4, 0);
        wr(5, 0, 201); wr(5, 4, 0);
        chk("pre_update_pending", pending, 2);
        wr(5, 0, 777);
        line(479);
        line(480, 1'b1);
        chk("commit_at_update_pending", pending, 1);
        line(524);
        chk_bnd("cau_scan0_prev", 201, 40, 50, 60);
        line(0);
        chk_bnd("cau_scan1_prev", 200, 40, 50, 60);
        line(479);
        line(480);
        chk("cau_next_pending", pending, 0);
        line(524);
        chk_bnd("cau_scan0_row", 777, 40, 50, 60);

        // 600 single-row frames, wrapping the top pointer.
        for (int f = 0; f < 600; f++) rand_frame();

        // Reset asserted mid-fetch at hcount 1281.
        step(0, 10);
        step(1280, 10);
        hcount         = 11'd1281;
        bus.write      = 1'b0;
        bus.chipselect = 1'b0;
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk_bnd("midrst_boundary", 0, 0, 0, 0);
        chk("midrst_pending", pending, 0);
        chk("midrst_overflow", overflow, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1282, 10);
        step(1283, 10);
        step(1599, 10);
        chk_bnd("midrst_hold", 0, 0, 0, 0);
        line(11);
        chk("midrst_row_known", m_valid[12], 1);
        chk("midrst_refetch", {b1, b2, b3, b4}, m_mem[12]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/river_row_buffer.md
# river_row_buffer

Scrolling per-scanline terrain store that sits directly upstream of the VGA pixel generator and drives its `boundary_1`..`boundary_4` inputs. Software pushes one terrain row at a time (four river-edge columns) over the Avalon write port. The block keeps a 512-row circular buffer and applies all rows pushed during a frame as a single scroll step at the start of vertical blanking, so the picture never tears. During each horizontal blanking interval it fetches the row for the next visible scanline and holds it stable for the whole line.

## Interface
- `DEPTH`, 512: rows in circular buffer; power of two; pointers are log2(DEPTH) = 9 bits.
- `VISIBLE`, 480: visible scanlines.
- `BW`, 10: boundary width in pixel columns.
- `PEND_MAX`, 31: maximum rows committed per frame; must be ≤ DEPTH−VISIBLE−1.
- `clk` in 1: 50 MHz system clock, same clock that drives `vga_counters`.
- `reset_n` in 1: reset, asynchronous, active-low.
- `writedata` in 16: Avalon write data.
- `write` in 1: Avalon write strobe.
- `chipselect` in 1: Avalon select.
- `address` in 3: register select.
- `hcount` in 11: from `vga_counters`, 0..1599.
- `vcount` in 10: from `vga_counters`, 0..524.
- `boundary_1`..`boundary_4` out BW each: edges for the current scanline.
- `pending` out 6: rows committed this frame, not yet scrolled in.
- `overflow` out 1: sticky; a commit was dropped.

## Operation
- Register map (write-only; acts only when `chipselect && write`):
  - 0–3: staging regs `stage_1`..`stage_4` <= `writedata[9:0]`.
  - 4: commit.
  - 5: clear `overflow`; `writedata` is ignored.
  - 6–7: ignored.
- Staging regs persist across commits.
- State:
  - `top_ptr` (9b): RAM row shown on scanline 0.
  - `pending` (6b).
  - Row RAM: DEPTH×4·BW, simple dual-port, synchronous read, one write port and one read port, never in conflict.
- Commit with `pending < PEND_MAX`:
  - RAM[(top_ptr − 1 − pending) mod DEPTH] <= {stage_1..stage_4}.
  - `pending` <= `pending` + 1.
- Commit with `pending == PEND_MAX`: RAM is untouched, `pending` holds, `overflow` <= 1.
- Frame update, on the cycle where `vcount == VISIBLE && hcount == 0`:
  - `top_ptr` <= `top_ptr` − `pending` (mod DEPTH).
  - `pending` <= 0.
- Commit on the same cycle as the frame update:
  - The write address is computed from the new `top_ptr`: (new_top − 1) mod DEPTH.
  - `pending` <= 1, so the row belongs to the next frame.
- Clear and overflow on the same cycle: set wins.
- Line fetch FSM, states IDLE → READ → LOAD → IDLE:
  - IDLE → READ when `hcount == 1280`.
    - Computes next = (vcount == 524) ? 0 : vcount + 1.
    - If next < VISIBLE, read address = (top_ptr + next) mod DEPTH.
    - Otherwise READ/LOAD are suppressed: the FSM returns to IDLE and the boundaries hold.
  - READ → LOAD: RAM data is valid.
  - LOAD: `boundary_n` registers <= RAM fields; then → IDLE.
- Consequences of fetch timing:
  - Boundaries change only in horizontal blanking.
  - Line 0 of a frame already uses the `top_ptr` updated at vcount 480.
- Rows pushed within the same frame: the newest row ends up on scanline 0 and earlier rows sit below it.

## Timing
- Reset (async assert, sync release):
  - `top_ptr` = 0, `pending` = 0, `overflow` = 0, `boundary_1..4` = 0.
  - Staging regs = 0, FSM = IDLE.
  - RAM contents are not reset.
- Reset mid-fetch: FSM returns to IDLE and outputs go to 0; the next fetch occurs at the next `hcount == 1280`.
- Fetch latency, with N the cycle where `hcount == 1280`:
  - Read issued at N.
  - Data valid at N+1.
  - Outputs update at the edge ending N+2, so they are visible at `hcount == 1283`.
- Commit latency:
  - `pending` and `overflow` update on the clock edge after the write cycle.
  - A RAM write lands at that same edge.
- Wrap-around:
  - All pointer arithmetic is mod DEPTH via 9-bit truncation.
  - `top_ptr` 0 − 3 = 509.
- Commits are accepted on every cycle; there is no backpressure.

## Test plan
- Reset, then commit rows A = {10,20,0,0} and B = {30,40,50,60}, then wait for a frame update:
  - After the update, `top_ptr` = 510 and `pending` = 0.
  - Scanline 0 shows B, scanline 1 shows A.
  - Boundaries stable for `hcount` 0..1279.
- Thirty-two commits in one frame:
  - `pending` = 31 and `overflow` = 1.
  - After the frame, `top_ptr` decreases by 31.
  - A write to address 5 returns `overflow` to 0.
- Commit asserted exactly at `vcount == 480, hcount == 0` with `pending` = 2:
  - `top_ptr` decreases by 2 and `pending` = 1.
  - The row lands at (new_top − 1) mod 512 and appears on scanline 0 one frame later.
- Across lines, check that boundaries change only at `hcount == 1283`, that vcount 479 → 480..523 holds the last value, and that the fetch at vcount 524 loads scanline 0.
- Drive 600 single-row frames; `top_ptr` must wrap 0 → 511 with scanline mapping correct across the wrap.
- Assert `reset_n` low at `hcount == 1281`: outputs are 0 immediately, and a correct fetch occurs on the following line.
